// File: rtl/uvma_rvfi_pkg.sv
// Shared RVFI widths, default core widths and the IXL encoding used by the retire emitter.
// Also holds the interrupt-tracker state type.
package uvma_rvfi_pkg;

    localparam int ORDER_WL       = 64;
    localparam int MODE_WL        = 2;
    localparam int IXL_WL         = 2;
    localparam int GPR_ADDR_WL    = 5;
    localparam int MAX_INTR_ID_WL = 11;
    localparam int DEFAULT_ILEN   = 32;
    localparam int DEFAULT_XLEN   = 32;

    typedef enum logic [IXL_WL-1:0] {
        IXL_NONE = 2'd0,
        IXL_32   = 2'd1,
        IXL_64   = 2'd2,
        IXL_128  = 2'd3
    } ixl_e;

    typedef enum logic [0:0] {
        INTR_IDLE    = 1'b0,
        INTR_PENDING = 1'b1
    } intr_state_e;

    function automatic ixl_e xlen_to_ixl(input int xlen);
        ixl_e enc;
        case (xlen)
            32:      enc = IXL_32;
            64:      enc = IXL_64;
            128:     enc = IXL_128;
            default: enc = IXL_NONE;
        endcase
        return enc;
    endfunction

endpackage

// File: rtl/rvfi_intr_tracker.sv
// Remembers the most recent interrupt entry until the next retirement claims it.
// A newer entry always overwrites an unclaimed one.
module rvfi_intr_tracker
    import uvma_rvfi_pkg::*;
#(
    parameter int ILEN = DEFAULT_ILEN
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      irq_taken_i,
    input  logic [MAX_INTR_ID_WL-1:0] irq_id_i,
    input  logic [ILEN-1:0]           mcause_i,
    input  logic                      consume_i,
    output logic                      intr_flag,
    output logic [MAX_INTR_ID_WL-1:0] intr_id,
    output logic [ILEN-1:0]           mcause_latched
);

    intr_state_e               state_q, state_d;
    logic [MAX_INTR_ID_WL-1:0] id_q, id_d;
    logic [ILEN-1:0]           mcause_q, mcause_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= INTR_IDLE;
            id_q     <= '0;
            mcause_q <= '0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            mcause_q <= mcause_d;
        end
    end

    // A fresh entry wins over a consume in the same cycle: the retirement sees the old state.
    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        mcause_d = mcause_q;
        case (state_q)
            INTR_IDLE: begin
                if (irq_taken_i) begin
                    state_d  = INTR_PENDING;
                    id_d     = irq_id_i;
                    mcause_d = mcause_i;
                end else begin
                    state_d  = INTR_IDLE;
                end
            end
            INTR_PENDING: begin
                if (irq_taken_i) begin
                    state_d  = INTR_PENDING;
                    id_d     = irq_id_i;
                    mcause_d = mcause_i;
                end else if (consume_i) begin
                    state_d  = INTR_IDLE;
                end else begin
                    state_d  = INTR_PENDING;
                end
            end
            default: begin
                state_d  = INTR_IDLE;
            end
        endcase
    end

    assign intr_flag      = (state_q == INTR_PENDING);
    assign intr_id        = id_q;
    assign mcause_latched = mcause_q;

endmodule

// File: rtl/rvfi_retire_emitter.sv
// Registers writeback retirements onto the RVFI port, numbering each one and attaching
// interrupt-entry metadata; trapped instructions and x0 writes are sanitised on the way.
module rvfi_retire_emitter
    import uvma_rvfi_pkg::*;
#(
    parameter int ILEN = DEFAULT_ILEN,
    parameter int XLEN = DEFAULT_XLEN
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      wb_valid_i,
    input  logic [ILEN-1:0]           wb_insn_i,
    input  logic [XLEN-1:0]           wb_pc_i,
    input  logic [XLEN-1:0]           wb_next_pc_i,
    input  logic                      wb_trap_i,
    input  logic                      wb_halt_i,
    input  logic [MODE_WL-1:0]        wb_mode_i,
    input  logic [GPR_ADDR_WL-1:0]    wb_rs1_addr_i,
    input  logic [GPR_ADDR_WL-1:0]    wb_rs2_addr_i,
    input  logic [XLEN-1:0]           wb_rs1_rdata_i,
    input  logic [XLEN-1:0]           wb_rs2_rdata_i,
    input  logic [GPR_ADDR_WL-1:0]    wb_rd_addr_i,
    input  logic [XLEN-1:0]           wb_rd_wdata_i,
    input  logic [XLEN-1:0]           wb_mem_addr_i,
    input  logic [XLEN-1:0]           wb_mem_rdata_i,
    input  logic [XLEN-1:0]           wb_mem_wdata_i,
    input  logic [XLEN/8-1:0]         wb_mem_rmask_i,
    input  logic [XLEN/8-1:0]         wb_mem_wmask_i,
    input  logic                      irq_taken_i,
    input  logic [MAX_INTR_ID_WL-1:0] irq_id_i,
    input  logic [ILEN-1:0]           mcause_i,
    input  logic [ILEN-1:0]           mip_i,
    output logic                      rvfi_valid,
    output logic [ORDER_WL-1:0]       rvfi_order,
    output logic [ILEN-1:0]           rvfi_insn,
    output logic                      rvfi_trap,
    output logic                      rvfi_halt,
    output logic                      rvfi_intr,
    output logic [MAX_INTR_ID_WL-1:0] rvfi_intr_id,
    output logic [MODE_WL-1:0]        rvfi_mode,
    output logic [IXL_WL-1:0]         rvfi_ixl,
    output logic [XLEN-1:0]           rvfi_pc_rdata,
    output logic [XLEN-1:0]           rvfi_pc_wdata,
    output logic [GPR_ADDR_WL-1:0]    rvfi_rs1_addr,
    output logic [GPR_ADDR_WL-1:0]    rvfi_rs2_addr,
    output logic [GPR_ADDR_WL-1:0]    rvfi_rs3_addr,
    output logic [XLEN-1:0]           rvfi_rs1_rdata,
    output logic [XLEN-1:0]           rvfi_rs2_rdata,
    output logic [XLEN-1:0]           rvfi_rs3_rdata,
    output logic [GPR_ADDR_WL-1:0]    rvfi_rd1_addr,
    output logic [GPR_ADDR_WL-1:0]    rvfi_rd2_addr,
    output logic [XLEN-1:0]           rvfi_rd1_wdata,
    output logic [XLEN-1:0]           rvfi_rd2_wdata,
    output logic [XLEN-1:0]           rvfi_mem_addr,
    output logic [XLEN-1:0]           rvfi_mem_rdata,
    output logic [XLEN-1:0]           rvfi_mem_wdata,
    output logic [XLEN/8-1:0]         rvfi_mem_rmask,
    output logic [XLEN/8-1:0]         rvfi_mem_wmask,
    output logic [ILEN-1:0]           csr_mcause,
    output logic [ILEN-1:0]           csr_mip
);

    localparam int   MASK_WL = XLEN / 8;
    localparam ixl_e IXL_ENC = xlen_to_ixl(XLEN);

    logic                      intr_flag_s;
    logic [MAX_INTR_ID_WL-1:0] intr_id_s;
    logic [ILEN-1:0]           mcause_latched_s;

    rvfi_intr_tracker #(
        .ILEN (ILEN)
    ) u_intr_tracker (
        .clk            (clk),
        .reset_n        (reset_n),
        .irq_taken_i    (irq_taken_i),
        .irq_id_i       (irq_id_i),
        .mcause_i       (mcause_i),
        .consume_i      (wb_valid_i),
        .intr_flag      (intr_flag_s),
        .intr_id        (intr_id_s),
        .mcause_latched (mcause_latched_s)
    );

    logic [ORDER_WL-1:0]       order_q, order_d;
    logic                      valid_q, valid_d;
    logic [ORDER_WL-1:0]       rvfi_order_q, rvfi_order_d;
    logic [ILEN-1:0]           insn_q, insn_d;
    logic                      trap_q, trap_d, halt_q, halt_d, intr_q, intr_d;
    logic [MAX_INTR_ID_WL-1:0] intr_id_q, intr_id_d;
    logic [MODE_WL-1:0]        mode_q, mode_d;
    logic [IXL_WL-1:0]         ixl_q, ixl_d;
    logic [XLEN-1:0]           pc_rdata_q, pc_rdata_d, pc_wdata_q, pc_wdata_d;
    logic [GPR_ADDR_WL-1:0]    rs1_addr_q, rs1_addr_d, rs2_addr_q, rs2_addr_d, rd1_addr_q, rd1_addr_d;
    logic [XLEN-1:0]           rs1_rdata_q, rs1_rdata_d, rs2_rdata_q, rs2_rdata_d, rd1_wdata_q, rd1_wdata_d;
    logic [XLEN-1:0]           mem_addr_q, mem_addr_d, mem_rdata_q, mem_rdata_d, mem_wdata_q, mem_wdata_d;
    logic [MASK_WL-1:0]        mem_rmask_q, mem_rmask_d, mem_wmask_q, mem_wmask_d;
    logic [ILEN-1:0]           mcause_q, mcause_d, mip_q, mip_d;

    // Next values: load from writeback on a retirement, otherwise hold everything but the strobe.
    always_comb begin
        order_d      = order_q;
        valid_d      = 1'b0;
        rvfi_order_d = rvfi_order_q;
        insn_d       = insn_q;
        trap_d       = trap_q;
        halt_d       = halt_q;
        intr_d       = intr_q;
        intr_id_d    = intr_id_q;
        mode_d       = mode_q;
        ixl_d        = IXL_ENC;
        pc_rdata_d   = pc_rdata_q;
        pc_wdata_d   = pc_wdata_q;
        rs1_addr_d   = rs1_addr_q;
        rs2_addr_d   = rs2_addr_q;
        rs1_rdata_d  = rs1_rdata_q;
        rs2_rdata_d  = rs2_rdata_q;
        rd1_addr_d   = rd1_addr_q;
        rd1_wdata_d  = rd1_wdata_q;
        mem_addr_d   = mem_addr_q;
        mem_rdata_d  = mem_rdata_q;
        mem_wdata_d  = mem_wdata_q;
        mem_rmask_d  = mem_rmask_q;
        mem_wmask_d  = mem_wmask_q;
        mcause_d     = mcause_q;
        mip_d        = mip_q;
        if (wb_valid_i) begin
            order_d      = order_q + ORDER_WL'(1);
            valid_d      = 1'b1;
            rvfi_order_d = order_q;
            insn_d       = wb_insn_i;
            trap_d       = wb_trap_i;
            halt_d       = wb_halt_i;
            intr_d       = intr_flag_s;
            intr_id_d    = intr_flag_s ? intr_id_s : '0;
            mode_d       = wb_mode_i;
            pc_rdata_d   = wb_pc_i;
            pc_wdata_d   = wb_next_pc_i;
            rs1_addr_d   = wb_rs1_addr_i;
            rs2_addr_d   = wb_rs2_addr_i;
            rs1_rdata_d  = wb_rs1_rdata_i;
            rs2_rdata_d  = wb_rs2_rdata_i;
            rd1_addr_d   = wb_trap_i ? '0 : wb_rd_addr_i;
            rd1_wdata_d  = (wb_trap_i || (wb_rd_addr_i == '0)) ? '0 : wb_rd_wdata_i;
            mem_addr_d   = wb_mem_addr_i;
            mem_rdata_d  = wb_mem_rdata_i;
            mem_wdata_d  = wb_mem_wdata_i;
            mem_rmask_d  = wb_trap_i ? '0 : wb_mem_rmask_i;
            mem_wmask_d  = wb_trap_i ? '0 : wb_mem_wmask_i;
            mcause_d     = intr_flag_s ? mcause_latched_s : mcause_i;
            mip_d        = mip_i;
        end else begin
            valid_d      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            order_q      <= '0;
            valid_q      <= 1'b0;
            rvfi_order_q <= '0;
            insn_q       <= '0;
            trap_q       <= 1'b0;
            halt_q       <= 1'b0;
            intr_q       <= 1'b0;
            intr_id_q    <= '0;
            mode_q       <= '0;
            ixl_q        <= '0;
            pc_rdata_q   <= '0;
            pc_wdata_q   <= '0;
            rs1_addr_q   <= '0;
            rs2_addr_q   <= '0;
            rs1_rdata_q  <= '0;
            rs2_rdata_q  <= '0;
            rd1_addr_q   <= '0;
            rd1_wdata_q  <= '0;
            mem_addr_q   <= '0;
            mem_rdata_q  <= '0;
            mem_wdata_q  <= '0;
            mem_rmask_q  <= '0;
            mem_wmask_q  <= '0;
            mcause_q     <= '0;
            mip_q        <= '0;
        end else begin
            order_q      <= order_d;
            valid_q      <= valid_d;
            rvfi_order_q <= rvfi_order_d;
            insn_q       <= insn_d;
            trap_q       <= trap_d;
            halt_q       <= halt_d;
            intr_q       <= intr_d;
            intr_id_q    <= intr_id_d;
            mode_q       <= mode_d;
            ixl_q        <= ixl_d;
            pc_rdata_q   <= pc_rdata_d;
            pc_wdata_q   <= pc_wdata_d;
            rs1_addr_q   <= rs1_addr_d;
            rs2_addr_q   <= rs2_addr_d;
            rs1_rdata_q  <= rs1_rdata_d;
            rs2_rdata_q  <= rs2_rdata_d;
            rd1_addr_q   <= rd1_addr_d;
            rd1_wdata_q  <= rd1_wdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_rdata_q  <= mem_rdata_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_rmask_q  <= mem_rmask_d;
            mem_wmask_q  <= mem_wmask_d;
            mcause_q     <= mcause_d;
            mip_q        <= mip_d;
        end
    end

    assign rvfi_valid     = valid_q;
    assign rvfi_order     = rvfi_order_q;
    assign rvfi_insn      = insn_q;
    assign rvfi_trap      = trap_q;
    assign rvfi_halt      = halt_q;
    assign rvfi_intr      = intr_q;
    assign rvfi_intr_id   = intr_id_q;
    assign rvfi_mode      = mode_q;
    assign rvfi_ixl       = ixl_q;
    assign rvfi_pc_rdata  = pc_rdata_q;
    assign rvfi_pc_wdata  = pc_wdata_q;
    assign rvfi_rs1_addr  = rs1_addr_q;
    assign rvfi_rs2_addr  = rs2_addr_q;
    assign rvfi_rs3_addr  = '0;
    assign rvfi_rs1_rdata = rs1_rdata_q;
    assign rvfi_rs2_rdata = rs2_rdata_q;
    assign rvfi_rs3_rdata = '0;
    assign rvfi_rd1_addr  = rd1_addr_q;
    assign rvfi_rd2_addr  = '0;
    assign rvfi_rd1_wdata = rd1_wdata_q;
    assign rvfi_rd2_wdata = '0;
    assign rvfi_mem_addr  = mem_addr_q;
    assign rvfi_mem_rdata = mem_rdata_q;
    assign rvfi_mem_wdata = mem_wdata_q;
    assign rvfi_mem_rmask = mem_rmask_q;
    assign rvfi_mem_wmask = mem_wmask_q;
    assign csr_mcause     = mcause_q;
    assign csr_mip        = mip_q;

endmodule

// File: tb/tb_rvfi_retire_emitter.sv
// Scoreboard bench for rvfi_retire_emitter: a driver pushes model-predicted retirements,
// an independent monitor pops and compares them whenever rvfi_valid is seen.
module tb_rvfi_retire_emitter;

    typedef struct packed {
        logic        valid;
        logic [31:0] insn, pc, npc;
        logic        trap, halt;
        logic [1:0]  mode;
        logic [4:0]  rs1a, rs2a, rda;
        logic [31:0] rs1d, rs2d, rdw, maddr, mrd, mwd;
        logic [3:0]  rmask, wmask;
        logic        irq;
        logic [10:0] irq_id;
        logic [31:0] mcause, mip;
    } stim_t;

    typedef struct packed {
        logic [63:0] order;
        logic [31:0] insn;
        logic        trap, halt, intr;
        logic [10:0] intr_id;
        logic [1:0]  mode, ixl;
        logic [31:0] pc_r, pc_w;
        logic [4:0]  rs1a, rs2a, rs3a, rd1a, rd2a;
        logic [31:0] rs1d, rs2d, rs3d, rd1d, rd2d, maddr, mrd, mwd;
        logic [3:0]  rmask, wmask;
        logic [31:0] mcause, mip;
    } rec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        wb_valid_i = 1'b0, wb_trap_i = 1'b0, wb_halt_i = 1'b0, irq_taken_i = 1'b0;
    logic [31:0] wb_insn_i = '0, wb_pc_i = '0, wb_next_pc_i = '0;
    logic [1:0]  wb_mode_i = '0;
    logic [4:0]  wb_rs1_addr_i = '0, wb_rs2_addr_i = '0, wb_rd_addr_i = '0;
    logic [31:0] wb_rs1_rdata_i = '0, wb_rs2_rdata_i = '0, wb_rd_wdata_i = '0;
    logic [31:0] wb_mem_addr_i = '0, wb_mem_rdata_i = '0, wb_mem_wdata_i = '0;
    logic [3:0]  wb_mem_rmask_i = '0, wb_mem_wmask_i = '0;
    logic [10:0] irq_id_i = '0;
    logic [31:0] mcause_i = '0, mip_i = '0;

    logic        rvfi_valid, rvfi_trap, rvfi_halt, rvfi_intr;
    logic [63:0] rvfi_order;
    logic [31:0] rvfi_insn, rvfi_pc_rdata, rvfi_pc_wdata;
    logic [10:0] rvfi_intr_id;
    logic [1:0]  rvfi_mode, rvfi_ixl;
    logic [4:0]  rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rs3_addr, rvfi_rd1_addr, rvfi_rd2_addr;
    logic [31:0] rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rs3_rdata, rvfi_rd1_wdata, rvfi_rd2_wdata;
    logic [31:0] rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata, csr_mcause, csr_mip;
    logic [3:0]  rvfi_mem_rmask, rvfi_mem_wmask;

    rvfi_retire_emitter dut (
        .clk(clk), .reset_n(reset_n), .wb_valid_i(wb_valid_i), .wb_insn_i(wb_insn_i),
        .wb_pc_i(wb_pc_i), .wb_next_pc_i(wb_next_pc_i), .wb_trap_i(wb_trap_i), .wb_halt_i(wb_halt_i),
        .wb_mode_i(wb_mode_i), .wb_rs1_addr_i(wb_rs1_addr_i), .wb_rs2_addr_i(wb_rs2_addr_i),
        .wb_rs1_rdata_i(wb_rs1_rdata_i), .wb_rs2_rdata_i(wb_rs2_rdata_i), .wb_rd_addr_i(wb_rd_addr_i),
        .wb_rd_wdata_i(wb_rd_wdata_i), .wb_mem_addr_i(wb_mem_addr_i), .wb_mem_rdata_i(wb_mem_rdata_i),
        .wb_mem_wdata_i(wb_mem_wdata_i), .wb_mem_rmask_i(wb_mem_rmask_i), .wb_mem_wmask_i(wb_mem_wmask_i),
        .irq_taken_i(irq_taken_i), .irq_id_i(irq_id_i), .mcause_i(mcause_i), .mip_i(mip_i),
        .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn), .rvfi_trap(rvfi_trap),
        .rvfi_halt(rvfi_halt), .rvfi_intr(rvfi_intr), .rvfi_intr_id(rvfi_intr_id), .rvfi_mode(rvfi_mode),
        .rvfi_ixl(rvfi_ixl), .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
        .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr), .rvfi_rs3_addr(rvfi_rs3_addr),
        .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata), .rvfi_rs3_rdata(rvfi_rs3_rdata),
        .rvfi_rd1_addr(rvfi_rd1_addr), .rvfi_rd2_addr(rvfi_rd2_addr), .rvfi_rd1_wdata(rvfi_rd1_wdata),
        .rvfi_rd2_wdata(rvfi_rd2_wdata), .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rdata(rvfi_mem_rdata),
        .rvfi_mem_wdata(rvfi_mem_wdata), .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask),
        .csr_mcause(csr_mcause), .csr_mip(csr_mip)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_tests = 0;
    int          n_fail  = 0;
    rec_t        exp_q[$];
    int unsigned due_q[$];
    logic [63:0] hold_order = '0;
    logic [31:0] hold_pc = '0;

    // Reference model state: retirement count and the unclaimed interrupt, if any.
    logic [63:0] m_order = '0;
    logic        m_pend = 1'b0;
    logic [10:0] m_id = '0;
    logic [31:0] m_mc = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic cmp_rec(input rec_t a, input rec_t e);
        chk("order", a.order, e.order);       chk("insn", a.insn, e.insn);
        chk("trap", a.trap, e.trap);          chk("halt", a.halt, e.halt);
        chk("intr", a.intr, e.intr);          chk("intr_id", a.intr_id, e.intr_id);
        chk("mode", a.mode, e.mode);          chk("ixl", a.ixl, e.ixl);
        chk("pc_rdata", a.pc_r, e.pc_r);      chk("pc_wdata", a.pc_w, e.pc_w);
        chk("rs1_addr", a.rs1a, e.rs1a);      chk("rs1_rdata", a.rs1d, e.rs1d);
        chk("rs2_addr", a.rs2a, e.rs2a);      chk("rs2_rdata", a.rs2d, e.rs2d);
        chk("rs3_addr", a.rs3a, e.rs3a);      chk("rs3_rdata", a.rs3d, e.rs3d);
        chk("rd1_addr", a.rd1a, e.rd1a);      chk("rd1_wdata", a.rd1d, e.rd1d);
        chk("rd2_addr", a.rd2a, e.rd2a);      chk("rd2_wdata", a.rd2d, e.rd2d);
        chk("mem_addr", a.maddr, e.maddr);    chk("mem_rdata", a.mrd, e.mrd);
        chk("mem_wdata", a.mwd, e.mwd);       chk("mem_rmask", a.rmask, e.rmask);
        chk("mem_wmask", a.wmask, e.wmask);   chk("csr_mcause", a.mcause, e.mcause);
        chk("csr_mip", a.mip, e.mip);
    endtask

    // Monitor: pop on every rvfi_valid, flag missing/unexpected strobes, check hold between strobes.
    always @(negedge clk) begin
        rec_t a;
        rec_t e;
        a = '{rvfi_order, rvfi_insn, rvfi_trap, rvfi_halt, rvfi_intr, rvfi_intr_id, rvfi_mode, rvfi_ixl,
              rvfi_pc_rdata, rvfi_pc_wdata, rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rs3_addr, rvfi_rd1_addr,
              rvfi_rd2_addr, rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rs3_rdata, rvfi_rd1_wdata, rvfi_rd2_wdata,
              rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata, rvfi_mem_rmask, rvfi_mem_wmask,
              csr_mcause, csr_mip};
        if (rvfi_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("latency", 64'(cyc), 64'(due_q.pop_front()));
                cmp_rec(a, e);
                hold_order = e.order;
                hold_pc    = e.pc_r;
            end
        end else if (exp_q.size() != 0 && due_q[0] == cyc) begin
            chk("missing_valid", 64'd0, 64'd1);
            void'(exp_q.pop_front());
            void'(due_q.pop_front());
        end else if (reset_n) begin
            chk("hold_order", rvfi_order, hold_order);
            chk("hold_pc", rvfi_pc_rdata, hold_pc);
        end
    end

    function automatic stim_t idle_stim();
        stim_t s;
        s = '0;
        s.mode = 2'd3;
        s.mip  = 32'h0000_0080;
        return s;
    endfunction

    function automatic stim_t rnd_stim();
        stim_t s;
        s.valid  = ($urandom_range(0, 9) < 7);
        s.insn   = $urandom;  s.pc = $urandom;  s.npc = $urandom;
        s.trap   = ($urandom_range(0, 6) == 0);
        s.halt   = ($urandom_range(0, 15) == 0);
        s.mode   = 2'($urandom);
        s.rs1a   = 5'($urandom);  s.rs2a = 5'($urandom);
        s.rda    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        s.rs1d   = $urandom;  s.rs2d = $urandom;  s.rdw = $urandom;
        s.maddr  = $urandom;  s.mrd = $urandom;  s.mwd = $urandom;
        s.rmask  = 4'($urandom);  s.wmask = 4'($urandom);
        s.irq    = ($urandom_range(0, 9) == 0);
        s.irq_id = 11'($urandom);
        s.mcause = $urandom;  s.mip = $urandom;
        return s;
    endfunction

    // One cycle of stimulus; the expected retirement comes from the model, not the DUT.
    task automatic apply(input stim_t s);
        rec_t e;
        @(posedge clk);
        #1;
        wb_valid_i = s.valid;      wb_insn_i = s.insn;        wb_pc_i = s.pc;
        wb_next_pc_i = s.npc;      wb_trap_i = s.trap;        wb_halt_i = s.halt;
        wb_mode_i = s.mode;        wb_rs1_addr_i = s.rs1a;    wb_rs2_addr_i = s.rs2a;
        wb_rs1_rdata_i = s.rs1d;   wb_rs2_rdata_i = s.rs2d;   wb_rd_addr_i = s.rda;
        wb_rd_wdata_i = s.rdw;     wb_mem_addr_i = s.maddr;   wb_mem_rdata_i = s.mrd;
        wb_mem_wdata_i = s.mwd;    wb_mem_rmask_i = s.rmask;  wb_mem_wmask_i = s.wmask;
        irq_taken_i = s.irq;       irq_id_i = s.irq_id;       mcause_i = s.mcause;
        mip_i = s.mip;
        if (s.valid) begin
            e = '0;
            e.order   = m_order;
            m_order   = m_order + 64'd1;
            e.insn    = s.insn;   e.trap = s.trap;  e.halt = s.halt;  e.mode = s.mode;
            e.ixl     = 2'd1;
            e.intr    = m_pend;
            e.intr_id = m_pend ? m_id : 11'd0;
            e.mcause  = m_pend ? m_mc : s.mcause;
            e.mip     = s.mip;
            e.pc_r    = s.pc;     e.pc_w = s.npc;
            e.rs1a    = s.rs1a;   e.rs1d = s.rs1d;  e.rs2a = s.rs2a;  e.rs2d = s.rs2d;
            e.rd1a    = s.trap ? 5'd0 : s.rda;
            e.rd1d    = (s.trap || s.rda == 5'd0) ? 32'd0 : s.rdw;
            e.maddr   = s.maddr;  e.mrd = s.mrd;    e.mwd = s.mwd;
            e.rmask   = s.trap ? 4'd0 : s.rmask;
            e.wmask   = s.trap ? 4'd0 : s.wmask;
            exp_q.push_back(e);
            due_q.push_back(cyc + 1);
        end
        if (s.irq) begin
            m_pend = 1'b1;
            m_id   = s.irq_id;
            m_mc   = s.mcause;
        end else if (s.valid) begin
            m_pend = 1'b0;
        end
    endtask

    // Reset with a retirement and an interrupt presented during it; both must vanish.
    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b0;  wb_valid_i = 1'b1;  irq_taken_i = 1'b1;  irq_id_i = 11'd9;
        m_order = '0;  m_pend = 1'b0;
        @(posedge clk);
        #1;
        wb_valid_i = 1'b0;  irq_taken_i = 1'b0;
        @(negedge clk);
        chk("rst_valid", rvfi_valid, 64'd0);      chk("rst_order", rvfi_order, 64'd0);
        chk("rst_insn", rvfi_insn, 64'd0);        chk("rst_pc_wdata", rvfi_pc_wdata, 64'd0);
        chk("rst_intr", rvfi_intr, 64'd0);        chk("rst_ixl", rvfi_ixl, 64'd0);
        chk("rst_mcause", csr_mcause, 64'd0);     chk("rst_rd1_wdata", rvfi_rd1_wdata, 64'd0);
        @(posedge clk);
        #1;
        hold_order = '0;  hold_pc = '0;
        reset_n = 1'b1;
    endtask

    initial begin
        stim_t s;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            s = idle_stim();  s.valid = 1'b1;  s.insn = 32'h0000_0013;
            s.pc = 32'h80 + 32'(4 * i);  s.npc = s.pc + 32'd4;  s.rda = 5'd1;  s.rdw = 32'(i);
            apply(s);
        end
        s = idle_stim();  s.valid = 1'b1;  s.insn = 32'h0000_0013;  s.pc = 32'h8C;  s.npc = 32'h90;
        s.rda = 5'd0;  s.rdw = 32'h55;  apply(s);
        s = idle_stim();  s.valid = 1'b1;  s.insn = 32'h0000_2283;  s.pc = 32'h90;  s.npc = 32'h100;
        s.trap = 1'b1;  s.rda = 5'd5;  s.rdw = 32'hDEAD;  s.rmask = 4'hF;  s.wmask = 4'h3;  apply(s);
        s = idle_stim();  s.irq = 1'b1;  s.irq_id = 11'd11;  s.mcause = 32'h8000_000B;  apply(s);
        for (int i = 0; i < 2; i++) begin
            s = idle_stim();  s.valid = 1'b1;  s.pc = 32'h200 + 32'(4 * i);  s.npc = s.pc + 32'd4;
            s.mcause = 32'h1234;  apply(s);
        end
        s = idle_stim();  s.valid = 1'b1;  s.pc = 32'h300;  s.irq = 1'b1;  s.irq_id = 11'd3;
        s.mcause = 32'h8000_0003;  apply(s);
        s = idle_stim();  s.valid = 1'b1;  s.pc = 32'h304;  apply(s);
        s = idle_stim();  s.irq = 1'b1;  s.irq_id = 11'd3;  s.mcause = 32'h8000_0003;  apply(s);
        s = idle_stim();  s.irq = 1'b1;  s.irq_id = 11'd7;  s.mcause = 32'h8000_0007;  apply(s);
        s = idle_stim();  s.valid = 1'b1;  s.pc = 32'h400;  apply(s);
        s = idle_stim();  s.irq = 1'b1;  s.irq_id = 11'd5;  s.mcause = 32'h8000_0005;  apply(s);
        s = idle_stim();  s.valid = 1'b1;  s.pc = 32'h500;  s.irq = 1'b1;  s.irq_id = 11'd9;
        s.mcause = 32'h8000_0009;  apply(s);
        s = idle_stim();  s.valid = 1'b1;  s.pc = 32'h504;  apply(s);
        apply(idle_stim());
        // Counter preload: the force spans an idle edge so the flop settles at all-ones.
        @(posedge clk);
        #1;
        force dut.order_q = {64{1'b1}};
        @(posedge clk);
        #1;
        release dut.order_q;
        m_order = {64{1'b1}};
        hold_order = rvfi_order;
        for (int i = 0; i < 2; i++) begin
            s = idle_stim();  s.valid = 1'b1;  s.pc = 32'h600 + 32'(4 * i);  apply(s);
        end
        s = idle_stim();  s.irq = 1'b1;  s.irq_id = 11'd2;  s.mcause = 32'h8000_0002;  apply(s);
        apply(idle_stim());
        do_reset();
        s = idle_stim();  s.valid = 1'b1;  s.pc = 32'h700;  apply(s);
        for (int i = 0; i < 400; i++) apply(rnd_stim());
        apply(idle_stim());
        apply(idle_stim());
        apply(idle_stim());
        chk("drain", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rvfi_retire_emitter.md
# rvfi_retire_emitter

Producer end of the RVFI instruction interface: takes per-instruction retirement data from a core's writeback stage and drives the `rvfi_*` and `csr_*` signals sampled by the passive RVFI monitor. It registers each retirement for one cycle and numbers it with a monotonically increasing `rvfi_order`. It also attaches interrupt-entry metadata and sanitises fields for trapped instructions and x0 writes. It sits in the core wrapper, between the writeback stage and the `uvma_rvfi_instr_if` instance.

## Interface
- ILEN, default DEFAULT_ILEN (32): instruction width.
- XLEN, default DEFAULT_XLEN (32): data/address width.
- Package widths used below: ORDER_WL = 64, MODE_WL = 2, IXL_WL = 2, GPR_ADDR_WL = 5, MAX_INTR_ID_WL = 11.
- Clocking: one clock `clk`; reset `reset_n` is synchronous and active-low.
- clk  in  1  clock.
- reset_n  in  1  synchronous active-low reset.
- wb_valid_i  in  1  one instruction retires this cycle.
- wb_insn_i  in  ILEN  instruction word.
- wb_pc_i / wb_next_pc_i  in  XLEN each  PC of the retiring instruction / PC of the next instruction.
- wb_trap_i / wb_halt_i  in  1 each  instruction trapped / last instruction before debug halt.
- wb_mode_i  in  MODE_WL  privilege mode.
- wb_rs1_addr_i, wb_rs2_addr_i  in  GPR_ADDR_WL each  source register indices.
- wb_rs1_rdata_i, wb_rs2_rdata_i  in  XLEN each  source register values.
- wb_rd_addr_i  in  GPR_ADDR_WL  destination register index.
- wb_rd_wdata_i  in  XLEN  destination register value.
- wb_mem_addr_i, wb_mem_rdata_i, wb_mem_wdata_i  in  XLEN each  memory access address, read data, write data.
- wb_mem_rmask_i, wb_mem_wmask_i  in  XLEN/8 each  memory read / write byte masks.
- irq_taken_i  in  1  pulse: the core has vectored to an interrupt handler.
- irq_id_i  in  MAX_INTR_ID_WL  interrupt id, valid with irq_taken_i.
- mcause_i, mip_i  in  ILEN each  live CSR values.
- rvfi_valid  out  1  retirement strobe.
- rvfi_order  out  ORDER_WL  retirement sequence number.
- rvfi_insn  out  ILEN  retired instruction word.
- rvfi_trap, rvfi_halt, rvfi_intr  out  1 each  trap / halt / first instruction of an interrupt handler.
- rvfi_intr_id  out  MAX_INTR_ID_WL  interrupt id for the handler's first instruction.
- rvfi_mode  out  MODE_WL  privilege mode.
- rvfi_ixl  out  IXL_WL  XLEN encoding.
- rvfi_pc_rdata, rvfi_pc_wdata  out  XLEN each  current PC / next PC.
- rvfi_rs1/2/3_addr  out  GPR_ADDR_WL each; rvfi_rs1/2/3_rdata  out  XLEN each  source operands.
- rvfi_rd1/2_addr  out  GPR_ADDR_WL each; rvfi_rd1/2_wdata  out  XLEN each  destination writes.
- rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata  out  XLEN each  memory access.
- rvfi_mem_rmask, rvfi_mem_wmask  out  XLEN/8 each  memory byte masks.
- csr_mcause, csr_mip  out  ILEN each  CSR snapshot.

## Operation
- **Output stage.** When `wb_valid_i` is high, all `rvfi_*` outputs load from the `wb_*` inputs on the next edge and `rvfi_valid` = 1. Otherwise `rvfi_valid` = 0 and all data fields hold their last values.
- **Order counter.** 64-bit counter; the first retirement after reset carries order 0 and each later one increments by 1. It wraps from 2^64-1 to 0 without any flag.
- **x0 writes.** If `wb_rd_addr_i` = 0, `rvfi_rd1_wdata` = 0 regardless of `wb_rd_wdata_i`.
- **Trapped instructions.** When `wb_trap_i` = 1:
  - `rvfi_rd1_addr`, `rvfi_rd1_wdata`, `rvfi_mem_rmask` and `rvfi_mem_wmask` are forced to 0.
  - `rvfi_pc_wdata` = `wb_next_pc_i`, which is the trap vector.
- **Unused lanes.** rs3/rd2 outputs are constant 0. `rvfi_ixl` is constant: 1 for XLEN = 32, 2 for XLEN = 64.
- **Interrupt tracker FSM**, states IDLE and PENDING:
  - IDLE → PENDING on `irq_taken_i`; latch `irq_id_i` and `mcause_i`.
  - PENDING → IDLE on the next `wb_valid_i`. That retirement gets `rvfi_intr` = 1, `rvfi_intr_id` = latched id, `csr_mcause` = latched value.
  - `irq_taken_i` in PENDING: the newer id and mcause overwrite the latched ones and the FSM stays PENDING (nested entry).
  - `irq_taken_i` and `wb_valid_i` in the same cycle from IDLE: the current retirement gets `rvfi_intr` = 0; the interrupt goes PENDING and applies to the next retirement.
  - Same cycle while already PENDING: the current retirement consumes the old pending interrupt, and the new one becomes pending.
- **CSR snapshot.** Outside interrupt-flagged retirements, `csr_mcause` = `mcause_i` and `csr_mip` = `mip_i`, sampled on the `wb_valid_i` cycle.

## Timing
- Latency from `wb_valid_i` to `rvfi_valid` is exactly 1 cycle. Back-to-back retirements give back-to-back `rvfi_valid` pulses. There is no backpressure.
- Reset (`reset_n` low at a clock edge): every output goes to 0, the order counter goes to 0, and the FSM goes to IDLE.
- Reset asserted mid-stream discards any pending interrupt and any in-flight retirement.
- `wb_valid_i` in the reset-release cycle is ignored.

## Structure
- Shared package `uvma_rvfi_pkg` holds ORDER_WL, MODE_WL, IXL_WL, GPR_ADDR_WL, MAX_INTR_ID_WL, DEFAULT_ILEN, DEFAULT_XLEN, and the IXL encoding typedef.
- One sub-module, `rvfi_intr_tracker`, contains the IDLE/PENDING FSM plus the latched id and mcause. It outputs `intr_flag`, `intr_id` and `mcause_latched`, and is consumed on `wb_valid_i`.

## Test plan
- Reset, then 3 back-to-back retirements at PC 0x80, 0x84, 0x88 -> `rvfi_valid` high on cycles 1, 2, 3 with order 0, 1, 2 and `pc_wdata` 0x84, 0x88, 0x8C.
- Retire `addi x0` with `wb_rd_wdata_i` = 0x55 -> `rvfi_rd1_addr` = 0, `rvfi_rd1_wdata` = 0.
- Trapping load with rd = 5 and rmask = 0xF -> `rvfi_trap` = 1, rd1_addr = 0, rmask = 0, `pc_wdata` = trap vector.
- `irq_taken_i` with id 11 and mcause 0x8000000B, then 2 retirements -> first has `rvfi_intr` = 1, intr_id = 11, `csr_mcause` = 0x8000000B; second has `rvfi_intr` = 0.
- `irq_taken_i` (id 3) in the same cycle as a retirement from IDLE -> that retirement has `intr` = 0, the following one has `intr` = 1 with id 3. Back-to-back `irq_taken_i` (id 3, then id 7) before any retirement -> the next retirement has `intr` = 1 with id 7.
- Preload the order counter to 2^64-1 via force, then 2 retirements -> orders 2^64-1, then 0. Assert reset while PENDING -> the next retirement after reset has `intr` = 0 and order 0.
